// File: rtl/tmds_encoder_nch.sv
// Multi-channel TMDS/HDMI symbol encoder: DVI video and control, HDMI guard band and TERC4.
// Three register stages (byte + ones count, q_m + N1, output symbol + disparity); mode is shared.
module tmds_encoder_nch #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic                    vga_clk,
    input  logic                    sys_rst,
    input  logic [1:0]              mode,
    input  logic [8*NUM_CH-1:0]     data_in,
    input  logic [2*NUM_CH-1:0]     ctrl_in,
    input  logic [4*NUM_CH-1:0]     terc4_in,
    output logic [10*NUM_CH-1:0]    data_out,
    output logic [CNT_W*NUM_CH-1:0] cnt_out
);
    localparam logic [1:0] MODE_CTRL  = 2'b00;
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_GUARD = 2'b10;

    localparam logic [9:0] CTRL_TAB [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    generate
        if (CNT_W < 5) begin : g_bad_cnt_w
            $error("tmds_encoder_nch: CNT_W must be at least 5");
        end
        if (NUM_CH < 1) begin : g_bad_num_ch
            $error("tmds_encoder_nch: NUM_CH must be at least 1");
        end
    endgenerate

    // Shared stage controls; fill_* keeps data_out at 0 until the first post-reset sample arrives.
    logic [1:0] mode_s1_reg, mode_s2_reg;
    logic       fill_s1_reg, fill_s2_reg;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_s1_reg <= MODE_CTRL;
            mode_s2_reg <= MODE_CTRL;
            fill_s1_reg <= 1'b0;
            fill_s2_reg <= 1'b0;
        end else begin
            mode_s1_reg <= mode;
            mode_s2_reg <= mode_s1_reg;
            fill_s1_reg <= 1'b1;
            fill_s2_reg <= fill_s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [9:0] GUARD_SYM = (gi % 2 == 0) ? 10'b1011001100 : 10'b0100110011;

            logic [7:0]              d_s1_reg;
            logic [3:0]              n1_s1_reg, n1_next;
            logic [1:0]              ctrl_s1_reg, ctrl_s2_reg;
            logic [3:0]              terc_s1_reg, terc_s2_reg;
            logic                    use_xnor;
            logic [8:0]              qm_next, qm_s2_reg;
            logic [3:0]              nq_next, nq_s2_reg;
            logic [9:0]              sym_reg, sym_next;
            logic signed [CNT_W-1:0] cnt_reg, cnt_next, nq_w, bal;

            always_comb begin
                n1_next = '0;
                for (int i = 0; i < 8; i++) begin
                    n1_next = n1_next + 4'(data_in[8*gi+i]);
                end
            end

            assign use_xnor = (n1_s1_reg > 4'd4) || ((n1_s1_reg == 4'd4) && !d_s1_reg[0]);

            always_comb begin
                qm_next    = '0;
                qm_next[0] = d_s1_reg[0];
                for (int i = 1; i < 8; i++) begin
                    qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d_s1_reg[i])
                                          :  (qm_next[i-1] ^ d_s1_reg[i]);
                end
                qm_next[8] = ~use_xnor;
                nq_next    = '0;
                for (int i = 0; i < 8; i++) begin
                    nq_next = nq_next + 4'(qm_next[i]);
                end
            end

            // bal = N1 - N0 = 2*N1 - 8; wrap in the intermediate shift cancels out modulo 2^CNT_W.
            assign nq_w = signed'(CNT_W'(nq_s2_reg));
            assign bal  = (nq_w <<< 1) - CNT_W'(8);

            always_comb begin
                sym_next = '0;
                cnt_next = '0;
                case (mode_s2_reg)
                    MODE_VIDEO: begin
                        if ((cnt_reg == '0) || (bal == '0)) begin
                            sym_next = {~qm_s2_reg[8], qm_s2_reg[8],
                                        qm_s2_reg[8] ? qm_s2_reg[7:0] : ~qm_s2_reg[7:0]};
                            cnt_next = qm_s2_reg[8] ? (cnt_reg + bal) : (cnt_reg - bal);
                        end else if (cnt_reg[CNT_W-1] == bal[CNT_W-1]) begin
                            sym_next = {1'b1, qm_s2_reg[8], ~qm_s2_reg[7:0]};
                            cnt_next = cnt_reg - bal + {{(CNT_W-2){1'b0}}, qm_s2_reg[8], 1'b0};
                        end else begin
                            sym_next = {1'b0, qm_s2_reg[8], qm_s2_reg[7:0]};
                            cnt_next = cnt_reg + bal - {{(CNT_W-2){1'b0}}, ~qm_s2_reg[8], 1'b0};
                        end
                    end
                    MODE_CTRL:  sym_next = CTRL_TAB[ctrl_s2_reg];
                    MODE_GUARD: sym_next = GUARD_SYM;
                    default:    sym_next = TERC4_TAB[terc_s2_reg];
                endcase
            end

            always_ff @(posedge vga_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    d_s1_reg    <= '0;
                    n1_s1_reg   <= '0;
                    ctrl_s1_reg <= '0;
                    terc_s1_reg <= '0;
                    qm_s2_reg   <= '0;
                    nq_s2_reg   <= '0;
                    ctrl_s2_reg <= '0;
                    terc_s2_reg <= '0;
                    sym_reg     <= '0;
                    cnt_reg     <= '0;
                end else begin
                    d_s1_reg    <= data_in[8*gi +: 8];
                    n1_s1_reg   <= n1_next;
                    ctrl_s1_reg <= ctrl_in[2*gi +: 2];
                    terc_s1_reg <= terc4_in[4*gi +: 4];
                    qm_s2_reg   <= qm_next;
                    nq_s2_reg   <= nq_next;
                    ctrl_s2_reg <= ctrl_s1_reg;
                    terc_s2_reg <= terc_s1_reg;
                    if (fill_s2_reg) begin
                        sym_reg <= sym_next;
                        cnt_reg <= cnt_next;
                    end else begin
                        sym_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
            end

            assign data_out[10*gi +: 10]      = sym_reg;
            assign cnt_out[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate
endmodule

// File: tb/tb_tmds_encoder_nch.sv
// Scoreboard bench for tmds_encoder_nch: stimulus pushes model results, a negedge monitor pops and compares.
module tb_tmds_encoder_nch;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 6;
    localparam int LAT    = 3;

    logic                    vga_clk;
    logic                    sys_rst;
    logic [1:0]              mode;
    logic [8*NUM_CH-1:0]     data_in;
    logic [2*NUM_CH-1:0]     ctrl_in;
    logic [4*NUM_CH-1:0]     terc4_in;
    logic [10*NUM_CH-1:0]    data_out;
    logic [CNT_W*NUM_CH-1:0] cnt_out;

    tmds_encoder_nch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .mode     (mode),
        .data_in  (data_in),
        .ctrl_in  (ctrl_in),
        .terc4_in (terc4_in),
        .data_out (data_out),
        .cnt_out  (cnt_out)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    localparam logic [9:0] CTRL_TOK [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };
    localparam logic [9:0] TERC_TOK [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    localparam logic [9:0] GB_EVEN = 10'b1011001100;
    localparam logic [9:0] GB_ODD  = 10'b0100110011;

    typedef struct {
        logic [1:0]              m;
        logic [10*NUM_CH-1:0]    sym;
        logic [CNT_W*NUM_CH-1:0] cnt;
    } exp_t;

    exp_t       exp_q [$];
    int         model_cnt [NUM_CH];
    int         errors = 0;
    int         checks = 0;
    int         txn = 0;
    logic       in_valid = 1'b0;
    logic       zero_expected = 1'b0;
    logic [LAT-1:0] v_pipe;

    // Reference DVI video encoding from the rules: ones counts and signed disparity as plain integers.
    function automatic logic [9:0] video_model(input logic [7:0] d, input int cnt_in, output int cnt_o);
        int         n1, ones, zeros;
        bit         use_xnor;
        logic [8:0] q;
        logic [9:0] s;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = use_xnor ? 1'b0 : 1'b1;
        ones     = $countones(q[7:0]);
        zeros    = 8 - ones;
        cnt_o    = cnt_in;
        if (cnt_in == 0 || ones == zeros) begin
            s     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_o = cnt_in + (q[8] ? (ones - zeros) : (zeros - ones));
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            s     = {1'b1, q[8], ~q[7:0]};
            cnt_o = cnt_in + 2 * int'(q[8]) + zeros - ones;
        end else begin
            s     = {1'b0, q[8], q[7:0]};
            cnt_o = cnt_in - 2 * (q[8] ? 0 : 1) + ones - zeros;
        end
        return s;
    endfunction

    function automatic logic [8*NUM_CH-1:0] rand_data();
        logic [8*NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[8*k +: 8] = 8'($urandom_range(255));
        return r;
    endfunction

    function automatic logic [2*NUM_CH-1:0] rand_ctrl();
        logic [2*NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[2*k +: 2] = 2'($urandom_range(3));
        return r;
    endfunction

    function automatic logic [4*NUM_CH-1:0] rand_terc();
        logic [4*NUM_CH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[4*k +: 4] = 4'($urandom_range(15));
        return r;
    endfunction

    task automatic issue(input logic [1:0] m, input logic [8*NUM_CH-1:0] d,
                         input logic [2*NUM_CH-1:0] c, input logic [4*NUM_CH-1:0] t);
        exp_t       e;
        logic [9:0] s;
        int         nc;
        e.m = m;
        for (int k = 0; k < NUM_CH; k++) begin
            case (m)
                2'b01: begin
                    s = video_model(d[8*k +: 8], model_cnt[k], nc);
                    model_cnt[k] = nc;
                end
                2'b00: begin s = CTRL_TOK[c[2*k +: 2]]; model_cnt[k] = 0; end
                2'b10: begin s = (k % 2 == 0) ? GB_EVEN : GB_ODD; model_cnt[k] = 0; end
                default: begin s = TERC_TOK[t[4*k +: 4]]; model_cnt[k] = 0; end
            endcase
            e.sym[10*k +: 10]      = s;
            e.cnt[CNT_W*k +: CNT_W] = model_cnt[k][CNT_W-1:0];
        end
        exp_q.push_back(e);
        mode     = m;
        data_in  = d;
        ctrl_in  = c;
        terc4_in = t;
        in_valid = 1'b1;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst  = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NUM_CH; k++) model_cnt[k] = 0;
        zero_expected = 1'b1;
        #1;
        checks++;
        if (data_out !== '0 || cnt_out !== '0) begin
            errors++;
            $display("FAIL async_reset: data_out=%h cnt_out=%h, required 0/0", data_out, cnt_out);
        end
        repeat (2) @(posedge vga_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    // Mirrors the fixed three-stage latency of the DUT so the monitor knows when a symbol is due.
    always @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) v_pipe <= '0;
        else         v_pipe <= {v_pipe[LAT-2:0], in_valid};
    end

    always @(negedge vga_clk) begin
        exp_t e;
        bit   bad;
        if (!sys_rst && v_pipe[LAT-1]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output slot with empty queue, data_out=%h", data_out);
            end else begin
                e   = exp_q.pop_front();
                bad = 1'b0;
                zero_expected = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    checks++;
                    if (data_out[10*k +: 10] !== e.sym[10*k +: 10]) begin
                        bad = 1'b1;
                        errors++;
                        $display("FAIL sym_ch%0d txn %0d mode=%b: got %b, required %b",
                                 k, txn, e.m, data_out[10*k +: 10], e.sym[10*k +: 10]);
                    end
                    checks++;
                    if (cnt_out[CNT_W*k +: CNT_W] !== e.cnt[CNT_W*k +: CNT_W]) begin
                        bad = 1'b1;
                        errors++;
                        $display("FAIL cnt_ch%0d txn %0d mode=%b: got %0d, required %0d", k, txn, e.m,
                                 $signed(cnt_out[CNT_W*k +: CNT_W]), $signed(e.cnt[CNT_W*k +: CNT_W]));
                    end
                end
                $display("txn %0d mode=%b data_out=%h cnt_out=%h %s", txn, e.m, data_out, cnt_out,
                         bad ? "bad" : "ok");
                txn++;
            end
        end else if (zero_expected) begin
            checks++;
            if (data_out !== '0 || cnt_out !== '0) begin
                errors++;
                $display("FAIL post_reset_zero: data_out=%h cnt_out=%h, required 0/0", data_out, cnt_out);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4*NUM_CH-1:0] nib;
        logic [1:0]          cur_mode;
        int                  run_left;
        sys_rst  = 1'b0;
        mode     = 2'b00;
        data_in  = '0;
        ctrl_in  = '0;
        terc4_in = '0;
        #1;
        do_reset();

        // Byte 00 from cnt=0: 0x100/-8, 0x3FF/+2, 0x100/-6.
        repeat (3) issue(2'b01, {NUM_CH{8'h00}}, '0, '0);
        // Byte FF from cnt=0 (control clears it first), then control 01 on the next symbol.
        issue(2'b00, '0, {NUM_CH{2'b00}}, '0);
        issue(2'b01, {NUM_CH{8'hFF}}, '0, '0);
        issue(2'b00, '0, {NUM_CH{2'b01}}, '0);
        // Control token sweep.
        for (int j = 0; j < 4; j++) issue(2'b00, rand_data(), {NUM_CH{2'(j)}}, '0);
        // Guard band, then TERC4 nibbles 0, 5, F (ch3 gets A).
        issue(2'b10, rand_data(), rand_ctrl(), rand_terc());
        nib = '0;
        nib[3:0] = 4'h0; nib[7:4] = 4'h5; nib[11:8] = 4'hF; nib[15:12] = 4'hA;
        issue(2'b11, rand_data(), rand_ctrl(), nib);
        for (int j = 0; j < 16; j++) issue(2'b11, rand_data(), rand_ctrl(), {NUM_CH{4'(j)}});

        // Reset in the middle of a video run.
        repeat (6) issue(2'b01, rand_data(), rand_ctrl(), rand_terc());
        do_reset();

        // Random traffic with mode runs of 1..7 symbols, biased toward video.
        run_left = 0;
        cur_mode = 2'b01;
        for (int n = 0; n < 300; n++) begin
            if (run_left == 0) begin
                cur_mode = ($urandom_range(1) == 1) ? 2'b01 : 2'($urandom_range(3));
                run_left = $urandom_range(7, 1);
            end
            issue(cur_mode, rand_data(), rand_ctrl(), rand_terc());
            run_left--;
        end

        in_valid = 1'b0;
        repeat (LAT + 2) @(posedge vga_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected symbols never appeared, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
